// File: rtl/matmul2x2_seq_ctrl.sv
// Sequenced 2x2 matrix multiplier: one shared DW x DW MAC steps the i/j/k loop nest, one step per clock.
// Optional build macro MATMUL_SAT_EN: saturate each element to 2^DW-1 and add a sticky sat_flag output.
module matmul2x2_seq_ctrl #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4*DW-1:0] A,
    input  logic [4*DW-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4*DW-1:0] Res,
`ifdef MATMUL_SAT_EN
    output logic            sat_flag,
`endif
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [4*DW-1:0]   r_a;
    logic [4*DW-1:0]   r_b;
    logic [2:0]        r_step;
    logic [2*DW:0]     r_acc;
    logic [DW-1:0]     r_res_el [4];

    logic              w_i;
    logic              w_j;
    logic              w_k;
    logic              w_accept;
    logic [DW-1:0]     w_a_el [4];
    logic [DW-1:0]     w_b_el [4];
    logic [DW-1:0]     w_a_sel;
    logic [DW-1:0]     w_b_sel;
    logic [2*DW-1:0]   w_prod;
    logic [2*DW:0]     w_acc_next;
    logic [DW-1:0]     w_elem;

    // Step counter bits are the loop indices: s = {i, j, k}.
    assign w_i = r_step[2];
    assign w_j = r_step[1];
    assign w_k = r_step[0];

    // Element e of a packed matrix sits at row e/2, column e%2, element 0 in the MSBs.
    always_comb begin
        for (int e = 0; e < 4; e++) begin
            w_a_el[e] = r_a[(3-e)*DW +: DW];
            w_b_el[e] = r_b[(3-e)*DW +: DW];
        end
    end

    assign w_a_sel    = w_a_el[{w_i, w_k}];
    assign w_b_sel    = w_b_el[{w_k, w_j}];
    assign w_prod     = {{DW{1'b0}}, w_a_sel} * {{DW{1'b0}}, w_b_sel};
    assign w_acc_next = (w_k ? r_acc : '0) + {1'b0, w_prod};
    assign w_accept   = (r_state == S_IDLE) && in_valid;

`ifdef MATMUL_SAT_EN
    logic w_sat;
    logic r_sat;

    assign w_sat    = |w_acc_next[2*DW:DW];
    assign w_elem   = w_sat ? {DW{1'b1}} : w_acc_next[DW-1:0];
    assign sat_flag = r_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat <= 1'b0;
        end else if (w_accept) begin
            r_sat <= 1'b0;
        end else if (r_state == S_CALC && w_k && w_sat) begin
            r_sat <= 1'b1;
        end
    end
`else
    assign w_elem = w_acc_next[DW-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output is decoded from r_state alone, so in_valid/out_ready never reach an output combinationally.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next_state = S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                if (r_step == 3'd7) w_next_state = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Result elements are reset too: an aborted operation must leave Res at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_step <= '0;
            r_acc  <= '0;
            for (int e = 0; e < 4; e++) r_res_el[e] <= '0;
        end else if (w_accept) begin
            r_a    <= A;
            r_b    <= B;
            r_step <= '0;
            r_acc  <= '0;
        end else if (r_state == S_CALC) begin
            r_acc  <= w_acc_next;
            r_step <= r_step + 3'd1;
            if (w_k) r_res_el[{w_i, w_j}] <= w_elem;
        end
    end

    assign Res = {r_res_el[0], r_res_el[1], r_res_el[2], r_res_el[3]};

endmodule

// File: tb/tb_matmul2x2_seq_ctrl.sv
// Self-checking bench for matmul2x2_seq_ctrl: vector table, corner sequences and randomized back-to-back traffic.
// Build with MATMUL_SAT_EN defined to exercise the saturating variant and sat_flag.
module tb_matmul2x2_seq_ctrl;

    localparam int DW   = 8;
    localparam int NB2B = 5;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [4*DW-1:0] A;
    logic [4*DW-1:0] B;
    logic            out_valid;
    logic            out_ready;
    logic [4*DW-1:0] Res;
    logic            busy;
`ifdef MATMUL_SAT_EN
    logic            sat_flag;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    matmul2x2_seq_ctrl #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Res       (Res),
`ifdef MATMUL_SAT_EN
        .sat_flag  (sat_flag),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        sat;
        int          hold;   // <0: out_ready raised early, else cycles of backpressure
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain matrix product on integers, then wrap or clamp each element.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        int          ma [2][2];
        int          mb [2][2];
        int          sum;
        logic [31:0] res;
        logic        sat;
        res = '0;
        sat = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                ma[r][c] = int'(a[(3-(2*r+c))*8 +: 8]);
                mb[r][c] = int'(b[(3-(2*r+c))*8 +: 8]);
            end
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                sum = ma[r][0]*mb[0][c] + ma[r][1]*mb[1][c];
                if (sum > 255) sat = 1'b1;
`ifdef MATMUL_SAT_EN
                if (sum > 255) sum = 255;
`else
                sum = sum % 256;
`endif
                res[(3-(2*r+c))*8 +: 8] = 8'(sum);
            end
        return {sat, res};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_in_ready(input string name);
        int n = 0;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        check({name, "_in_ready_wait"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input vec_t v);
        int lat;
        wait_in_ready(v.name);
        in_valid = 1'b1;
        A = v.a;
        B = v.b;
        tick();
        in_valid = 1'b0;
        A = $urandom;
        B = $urandom;
        if (v.hold < 0) out_ready = 1'b1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            check({v.name, "_busy_calc"}, 64'(busy), 64'd1);
            check({v.name, "_in_ready_calc"}, 64'(in_ready), 64'd0);
            tick();
            lat++;
        end
        check({v.name, "_latency"}, 64'(lat), 64'd8);
        check({v.name, "_res"}, 64'(Res), 64'(v.res));
        check({v.name, "_busy_done"}, 64'(busy), 64'd1);
`ifdef MATMUL_SAT_EN
        check({v.name, "_sat_flag"}, 64'(sat_flag), 64'(v.sat));
`endif
        for (int h = 0; h < v.hold; h++) begin
            in_valid = 1'b1;
            A = $urandom;
            B = $urandom;
            tick();
            check({v.name, "_bp_out_valid"}, 64'(out_valid), 64'd1);
            check({v.name, "_bp_res"}, 64'(Res), 64'(v.res));
            check({v.name, "_bp_in_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({v.name, "_post_out_valid"}, 64'(out_valid), 64'd0);
        check({v.name, "_post_in_ready"}, 64'(in_ready), 64'd1);
        check({v.name, "_post_busy"}, 64'(busy), 64'd0);
        check({v.name, "_res_retained"}, 64'(Res), 64'(v.res));
        tick();
        check({v.name, "_not_queued"}, 64'(in_ready), 64'd1);
    endtask

    vec_t        vecs [8];
    logic [32:0] m;
    vec_t        gen;

    initial begin
        vecs[0] = '{"identity", 32'h01000001, 32'h05060708, 32'h05060708, 1'b0, 0};
        vecs[1] = '{"general",  32'h01020304, 32'h05060708, 32'h13162B32, 1'b0, -1};
`ifdef MATMUL_SAT_EN
        vecs[2] = '{"overflow", 32'h10101010, 32'h10101010, 32'hFFFFFFFF, 1'b1, 5};
`else
        vecs[2] = '{"overflow", 32'h10101010, 32'h10101010, 32'h00000000, 1'b1, 5};
`endif
        vecs[3] = '{"identity2", 32'h01000001, 32'h05060708, 32'h05060708, 1'b0, 0};
        for (int n = 4; n < 8; n++) begin
            vecs[n].name = $sformatf("rand%0d", n);
            vecs[n].a    = $urandom;
            vecs[n].b    = $urandom;
            m            = model(vecs[n].a, vecs[n].b);
            vecs[n].res  = m[31:0];
            vecs[n].sat  = m[32];
            vecs[n].hold = n - 5;
        end
        gen = vecs[1];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        tick();
        tick();
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_res", 64'(Res), 64'd0);
`ifdef MATMUL_SAT_EN
        check("reset_sat_flag", 64'(sat_flag), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int n = 0; n < 8; n++) run_op(vecs[n]);

        // Abort in the middle of CALC at step 3.
        wait_in_ready("midreset");
        in_valid = 1'b1;
        A = gen.a;
        B = gen.b;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("midreset_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_res", 64'(Res), 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        check("midreset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            check("midreset_no_spurious_valid", 64'(out_valid), 64'd0);
        end
        gen.name = "after_reset";
        run_op(gen);

        // Back-to-back: in_valid and out_ready held high, operands change after each accept.
        begin
            int          cyc      = 0;
            int          last_acc = -1;
            int          n_acc    = 0;
            int          n_res    = 0;
            logic        acc_now;
            logic [32:0] mm;
            logic [31:0] exp_q [$];
            in_valid  = 1'b1;
            out_ready = 1'b1;
            A = $urandom;
            B = $urandom;
            while (n_res < NB2B && cyc < 300) begin
                acc_now = in_ready & in_valid;
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("b2b_unexpected_result", 64'(out_valid), 64'd0);
                    end else begin
                        check("b2b_res", 64'(Res), 64'(exp_q.pop_front()));
                    end
                    n_res++;
                end
                tick();
                cyc++;
                if (acc_now) begin
                    if (last_acc >= 0) check("b2b_period", 64'(cyc - last_acc), 64'd10);
                    last_acc = cyc;
                    mm = model(A, B);
                    exp_q.push_back(mm[31:0]);
                    n_acc++;
                    if (n_acc < NB2B) begin
                        A = $urandom;
                        B = $urandom;
                    end else begin
                        in_valid = 1'b0;
                    end
                end
            end
            check("b2b_accepts", 64'(n_acc), 64'(NB2B));
            check("b2b_results", 64'(n_res), 64'(NB2B));
            out_ready = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matmul2x2_seq_ctrl.md
Name: matmul2x2_seq_ctrl

Overview:
Sequenced 2x2 matrix multiplier for DW-bit elements. It time-shares one DW x DW multiplier and one accumulator, stepping through the i/j/k loop nest one MAC per clock. It has a valid/ready handshake on both input operands and the result. It sits between an operand source (CPU register block or DMA) and a result consumer, and replaces the fully combinational 4-multiplier array wherever area matters more than latency.

Parameters:
DW, 8, element width in bits. Operand and result buses are 4*DW wide.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
in_valid  input  1  A/B operands valid.
in_ready  output  1  block can accept operands (high only in IDLE).
A  input  4*DW  packed matrix A = {A00,A01,A10,A11}, A00 in the MSBs.
B  input  4*DW  packed matrix B, same packing as A.
out_valid  output  1  Res holds a completed product.
out_ready  input  1  consumer accepts Res.
Res  output  4*DW  packed result {R00,R01,R10,R11}, same packing as A.
busy  output  1  high in CALC or DONE.

Behaviour:
- Reset values (asynchronous, while rst_n=0): state=IDLE, in_ready=1, out_valid=0, busy=0, Res=0, step counter=0, accumulator=0, operand registers=0.
- States:
  - IDLE: in_ready=1. On in_valid & in_ready, capture A and B into internal registers, clear the accumulator and step counter, and go to CALC. A and B are don't-care after the accept edge.
  - CALC: in_ready=0 and busy=1.
    - A 3-bit step counter s={i,j,k} runs 0..7, one step per cycle.
    - Each cycle: acc_next = (k==0 ? 0 : acc) + A[i][k]*B[k][j]. The product is 2*DW bits; acc is 2*DW+1 bits.
    - When k==1, write element R[i][j] into the Res register from acc_next (width rule below).
    - After step 7, go to DONE.
  - DONE: out_valid=1. Res and out_valid hold stable while out_ready=0. On out_valid & out_ready, clear out_valid and go to IDLE.
- Latency and throughput:
  - out_valid rises exactly 8 clocks after the accept edge.
  - The next accept can occur no earlier than 1 clock after the output handshake, giving a minimum period of 10 clocks per operation.
- Res retains its last value in IDLE. Elements are overwritten progressively during CALC, so Res is valid only while out_valid=1.
- Width rule (default): each element is the low DW bits of the sum, i.e. sum modulo 2^DW. This matches the existing combinational multiplier bit-for-bit.
- Input-side boundaries:
  - in_valid asserted outside IDLE is ignored and is not queued.
  - The producer must hold in_valid until in_ready is seen.
- out_ready asserted before out_valid has no effect.
- Reset mid-operation: asserting rst_n low in any state aborts immediately and forces all reset values. There is no partial result and no spurious out_valid after release.
- No combinational path from in_valid or out_ready to any output.

Optional Feature:
- Macro MATMUL_SAT_EN.
- When defined: each result element saturates. If the full 2*DW+1-bit sum is >= 2^DW, the element becomes 2^DW-1, else it is the sum. A sticky output port sat_flag (1 bit) is added. It clears on accept and sets if any element of the current operation saturated. It is valid with out_valid and resets to 0.
- When undefined: modulo-2^DW wrap, and no sat_flag port.

Test Plan:
- Identity: A=32'h01000001, B=32'h05060708 -> out_valid exactly 8 clocks after accept, Res=32'h05060708, busy=1 from accept to handshake.
- General: A=32'h01020304, B=32'h05060708 -> Res=32'h13162B32 ([[19,22],[43,50]]).
- Overflow: A=B=32'h10101010 -> Res=32'h00000000 without the macro. With MATMUL_SAT_EN: Res=32'hFFFFFFFF and sat_flag=1. A follow-up identity test clears sat_flag to 0.
- Backpressure: hold out_ready=0 for 5 clocks after out_valid -> Res and out_valid stable, in_ready=0, a new in_valid is ignored. Raise out_ready -> IDLE next clock, in_ready=1.
- Reset mid-calc: assert rst_n=0 at CALC step 3 -> immediately out_valid=0, Res=0, in_ready=1. After release, a new operation (A=32'h01020304, B=32'h05060708) completes correctly.
- Back-to-back: in_valid and out_ready held high with changing operands -> an accept every 10 clocks, each Res correct, no operand lost or duplicated.
